id_hazard_branch_unit: RTL and testbench

ID_HAZARD_BRANCH_UNIT -- requirements
Module: id_hazard_branch_unit

---
 rtl/id_hazard_branch_unit.sv | 129 ++++++++++++
 tb/tb_id_hazard_branch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_branch_unit.sv
// Decode-stage hazard and branch unit: owns the IF/ID register, detects load-use
// and branch-operand hazards, and resolves BEQ/BNE in ID with a zero-cycle redirect.
module id_hazard_branch_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] IF_PC,
    input  logic [DATA_W-1:0] IF_instruction,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    input  logic              EX_MemRead,
    input  logic              EX_RegWrite,
    input  logic [4:0]        EX_Dest,
    output logic              BranchTaken,
    output logic [DATA_W-1:0] BranchOffset,
    output logic              PCWrite,
    output logic [DATA_W-1:0] ID_PC,
    output logic [DATA_W-1:0] ID_instruction,
    output logic              ID_valid,
    output logic              ID_bubble,
    output logic [4:0]        Rs,
    output logic [4:0]        Rt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD2 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic signed [DATA_W-1:0] sext_imm16(input logic signed [15:0] imm);
        return DATA_W'(imm);
    endfunction

    state_t            state_q, state_d;
    logic [DATA_W-1:0] id_pc_q, id_pc_d;
    logic [DATA_W-1:0] id_instr_q, id_instr_d;
    logic              id_valid_q, id_valid_d;

    logic [5:0] op;
    logic [4:0] rs_idx, rt_idx;
    logic       is_beq, is_bne, is_branch, rt_is_src;
    logic       hz_use, hold_req, stall, br_cond, br_taken;
    logic signed [DATA_W-1:0] offset_ext;

    assign op     = id_instr_q[31:26];
    assign rs_idx = id_instr_q[25:21];
    assign rt_idx = id_instr_q[20:16];

    assign is_beq    = (op == OP_BEQ);
    assign is_bne    = (op == OP_BNE);
    assign is_branch = is_beq || is_bne;
    // LW and unlisted opcodes use Rt as a destination or not at all.
    assign rt_is_src = (op == OP_RTYPE) || (op == OP_SW) || is_branch;

    assign hz_use = id_valid_q && EX_RegWrite && (EX_Dest != 5'd0) &&
                    ((EX_Dest == rs_idx) || (rt_is_src && (EX_Dest == rt_idx)));

    always_comb begin
        state_d  = state_q;
        hold_req = 1'b0;
        unique case (state_q)
            RUN: begin
                if (hz_use && (EX_MemRead || is_branch)) begin
                    hold_req = 1'b1;
                    state_d  = (EX_MemRead && is_branch) ? HOLD2 : HOLD1;
                end
            end
            HOLD2:   state_d = HOLD1;
            HOLD1:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign stall = (state_q != RUN) || hold_req;

    // Branch compare uses operands already forwarded by the datapath.
    assign br_cond  = id_valid_q &&
                      ((is_beq && (RsData == RtData)) || (is_bne && (RsData != RtData)));
    assign br_taken = !stall && br_cond;

    always_comb begin
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        if (!stall) begin
            id_pc_d = IF_PC;
            if (br_taken) begin
                id_instr_d = '0;
                id_valid_d = 1'b0;
            end else begin
                id_instr_d = IF_instruction;
                id_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            id_pc_q    <= '0;
            id_instr_q <= '0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign offset_ext     = sext_imm16(id_instr_q[15:0]);
    assign BranchOffset   = offset_ext;
    assign BranchTaken    = br_taken;
    assign PCWrite        = stall;
    assign ID_bubble      = stall;
    assign ID_PC          = id_pc_q;
    assign ID_instruction = id_instr_q;
    assign ID_valid       = id_valid_q;
    assign Rs             = rs_idx;
    assign Rt             = rt_idx;

endmodule

// File: tb/tb_id_hazard_branch_unit.sv
// Bench for id_hazard_branch_unit: directed scenarios plus randomized traffic,
// checked against a stall-counter model of the decode stage.
module tb_id_hazard_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IF_PC, IF_instruction, RsData, RtData;
    logic        EX_MemRead, EX_RegWrite;
    logic [4:0]  EX_Dest;
    logic        BranchTaken, PCWrite, ID_valid, ID_bubble;
    logic [31:0] BranchOffset, ID_PC, ID_instruction;
    logic [4:0]  Rs, Rt;

    always #5 clk = ~clk;

    id_hazard_branch_unit dut (
        .clk(clk), .rst(rst),
        .IF_PC(IF_PC), .IF_instruction(IF_instruction),
        .RsData(RsData), .RtData(RtData),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Dest(EX_Dest),
        .BranchTaken(BranchTaken), .BranchOffset(BranchOffset), .PCWrite(PCWrite),
        .ID_PC(ID_PC), .ID_instruction(ID_instruction), .ID_valid(ID_valid),
        .ID_bubble(ID_bubble), .Rs(Rs), .Rt(Rt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: IF/ID contents plus number of stall cycles still owed after this one.
    int          hold_cnt;
    logic [31:0] m_pc, m_instr;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        hold_cnt = 0;
        m_pc     = 32'h0;
        m_instr  = 32'h0;
        m_valid  = 1'b0;
    endtask

    task automatic model_eval(output logic e_stall, output logic e_taken, output logic e_br);
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic       rt_src, use_hz;
        op     = m_instr[31:26];
        rs     = m_instr[25:21];
        rt     = m_instr[20:16];
        e_br   = (op == 6'h04) || (op == 6'h05);
        rt_src = (op == 6'h00) || (op == 6'h2B) || e_br;
        use_hz = m_valid && EX_RegWrite && (EX_Dest != 0) &&
                 ((EX_Dest == rs) || (rt_src && (EX_Dest == rt)));
        e_stall = (hold_cnt > 0) || (use_hz && (EX_MemRead || e_br));
        e_taken = !e_stall && m_valid &&
                  (((op == 6'h04) && (RsData == RtData)) || ((op == 6'h05) && (RsData != RtData)));
    endtask

    task automatic model_edge();
        logic st, tk, br;
        if (!rst) begin
            model_reset();
        end else begin
            model_eval(st, tk, br);
            if (hold_cnt > 0)  hold_cnt = hold_cnt - 1;
            else if (st)       hold_cnt = (EX_MemRead && br) ? 2 : 1;
            if (!st) begin
                m_pc = IF_PC;
                if (tk) begin
                    m_instr = 32'h0;
                    m_valid = 1'b0;
                end else begin
                    m_instr = IF_instruction;
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        logic st, tk, br;
        #1;
        model_eval(st, tk, br);
        chk("PCWrite", {31'b0, PCWrite}, {31'b0, st});
        chk("ID_bubble", {31'b0, ID_bubble}, {31'b0, st});
        chk("BranchTaken", {31'b0, BranchTaken}, {31'b0, tk});
        chk("BranchOffset", BranchOffset, {{16{m_instr[15]}}, m_instr[15:0]});
        chk("ID_PC", ID_PC, m_pc);
        chk("ID_instruction", ID_instruction, m_instr);
        chk("ID_valid", {31'b0, ID_valid}, {31'b0, m_valid});
        chk("Rs", {27'b0, Rs}, {27'b0, m_instr[25:21]});
        chk("Rt", {27'b0, Rt}, {27'b0, m_instr[20:16]});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic ex_clear();
        EX_MemRead  = 1'b0;
        EX_RegWrite = 1'b0;
        EX_Dest     = 5'd0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 5))
            0:       op = 6'h00;
            1:       op = 6'h04;
            2:       op = 6'h05;
            3:       op = 6'h23;
            4:       op = 6'h2B;
            default: op = 6'($urandom_range(0, 63));
        endcase
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
    endfunction

    initial begin
        rst = 1'b0;
        IF_PC = 0; IF_instruction = 0; RsData = 0; RtData = 0;
        ex_clear();
        model_reset();

        // Reset state
        #2;
        check_all();
        chk("rst_PCWrite", {31'b0, PCWrite}, 32'd0);
        chk("rst_ID_valid", {31'b0, ID_valid}, 32'd0);
        chk("rst_BranchOffset", BranchOffset, 32'h0);
        chk("rst_Rs", {27'b0, Rs}, 32'd0);
        tick();
        rst = 1'b1;

        // Straight line
        IF_PC = 32'h04; IF_instruction = 32'h012A4020;
        check_all();
        tick();
        check_all();
        chk("sl_ID_PC", ID_PC, 32'h04);
        chk("sl_ID_valid", {31'b0, ID_valid}, 32'd1);
        chk("sl_PCWrite", {31'b0, PCWrite}, 32'd0);
        chk("sl_Rs", {27'b0, Rs}, 32'd9);
        chk("sl_Rt", {27'b0, Rt}, 32'd10);

        // Load-use on add $8,$9,$10
        EX_MemRead = 1; EX_RegWrite = 1; EX_Dest = 5'd9;
        IF_PC = 32'h08; IF_instruction = 32'h8D2B0000;
        check_all();
        chk("lu_PCWrite", {31'b0, PCWrite}, 32'd1);
        chk("lu_bubble", {31'b0, ID_bubble}, 32'd1);
        tick();
        check_all();
        chk("lu_hold_ID_PC", ID_PC, 32'h04);
        tick();
        ex_clear();
        check_all();
        chk("lu_resume_PCWrite", {31'b0, PCWrite}, 32'd0);
        tick();
        check_all();
        chk("lu_next_ID_PC", ID_PC, 32'h08);

        // BEQ $9 behind a load of $9, taken once resolved
        IF_PC = 32'h0C; IF_instruction = 32'h1120FFFE;
        check_all();
        tick();
        EX_MemRead = 1; EX_RegWrite = 1; EX_Dest = 5'd9;
        RsData = 32'd5; RtData = 32'd5;
        IF_PC = 32'h10; IF_instruction = 32'h012A4020;
        check_all();
        chk("bl_taken0", {31'b0, BranchTaken}, 32'd0);
        chk("bl_offset", BranchOffset, 32'hFFFFFFFE);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all();
            chk("bl_hold_taken", {31'b0, BranchTaken}, 32'd0);
            chk("bl_hold_PCWrite", {31'b0, PCWrite}, 32'd1);
        end
        tick();
        ex_clear();
        check_all();
        chk("bl_resolve_PCWrite", {31'b0, PCWrite}, 32'd0);
        chk("bl_resolve_taken", {31'b0, BranchTaken}, 32'd1);
        tick();
        check_all();
        chk("flush_valid", {31'b0, ID_valid}, 32'd0);
        chk("flush_instr", ID_instruction, 32'h0);
        chk("flush_pc", ID_PC, 32'h10);

        // BNE not taken
        IF_PC = 32'h14; IF_instruction = 32'h14220010;
        check_all();
        tick();
        RsData = 32'd7; RtData = 32'd7;
        IF_PC = 32'h18; IF_instruction = 32'h012A4020;
        check_all();
        chk("bne_taken", {31'b0, BranchTaken}, 32'd0);
        tick();
        check_all();
        chk("bne_next_instr", ID_instruction, 32'h012A4020);

        // Reset during HOLD2
        IF_PC = 32'h1C; IF_instruction = 32'h1120FFFE;
        check_all();
        tick();
        EX_MemRead = 1; EX_RegWrite = 1; EX_Dest = 5'd9;
        check_all();
        tick();
        check_all();
        chk("h2_PCWrite", {31'b0, PCWrite}, 32'd1);
        rst = 1'b0;
        model_reset();
        check_all();
        chk("arst_PCWrite", {31'b0, PCWrite}, 32'd0);
        chk("arst_ID_valid", {31'b0, ID_valid}, 32'd0);
        tick();
        rst = 1'b1;
        EX_Dest = 5'd0;
        IF_PC = 32'h20; IF_instruction = 32'h00004020;
        check_all();
        tick();
        check_all();
        chk("dest0_valid", {31'b0, ID_valid}, 32'd1);
        chk("dest0_PCWrite", {31'b0, PCWrite}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                model_reset();
                check_all();
                tick();
                rst = 1'b1;
            end
            IF_PC          = $urandom;
            IF_instruction = rand_instr();
            RsData         = 32'($urandom_range(0, 3));
            RtData         = ($urandom_range(0, 1) == 1) ? RsData : $urandom;
            EX_MemRead     = 1'($urandom_range(0, 1));
            EX_RegWrite    = ($urandom_range(0, 3) != 0);
            EX_Dest        = 5'($urandom_range(0, 4));
            check_all();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
